// File: rtl/mod_mul_il_seq.sv
// Sequencer for the interleaved modular multiplier: precompute kick-off, MSB-first digit walk, done pulse.
// Optional macro MMIL_SEQ_REUSE_EN adds reuse_i to skip precompute when the tables are already valid.
module mod_mul_il_seq #(
  parameter int NBITS = 4096,
  parameter int PBITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
`ifdef MMIL_SEQ_REUSE_EN
  input  logic             reuse_i,
`endif
  output logic             ready_o,
  input  logic [NBITS-1:0] a_i,
  output logic             pre_en_o,
  input  logic             pre_done_i,
  output logic             step_o,
  output logic [PBITS-1:0] digit_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o,
  output logic             busy_o
);

  localparam int NDIGITS = NBITS / PBITS;
  localparam int CW      = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIGITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT_PRE,
    S_RUN,
    S_FIN
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [NBITS-1:0] a_sh_reg;
  logic [CW-1:0]    cnt_reg;
  logic             accept;
  logic             fast_path;

  assign accept = start_i && (state_reg == S_IDLE);

`ifdef MMIL_SEQ_REUSE_EN
  // Tables stay valid once any precompute has completed; only reset invalidates them.
  logic pre_valid_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_valid_reg <= 1'b0;
    end else if (state_reg == S_WAIT_PRE && pre_done_i) begin
      pre_valid_reg <= 1'b1;
    end
  end

  assign fast_path = reuse_i && pre_valid_reg;
`else
  assign fast_path = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:     if (accept) state_next = fast_path ? S_RUN : S_PRE;
      S_PRE:      state_next = S_WAIT_PRE;
      S_WAIT_PRE: if (pre_done_i) state_next = S_RUN;
      S_RUN:      if (cnt_reg == '0) state_next = S_FIN;
      S_FIN:      state_next = S_IDLE;
      default:    state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_reg <= '0;
      cnt_reg  <= '0;
    end else if (accept) begin
      a_sh_reg <= a_i;
      cnt_reg  <= CNT_LAST;
    end else if (state_reg == S_RUN) begin
      a_sh_reg <= a_sh_reg << PBITS;
      cnt_reg  <= cnt_reg - CW'(1);
    end
  end

  // Every output decodes registered state only, so no input reaches an output combinationally.
  assign ready_o  = (state_reg == S_IDLE);
  assign busy_o   = (state_reg != S_IDLE);
  assign pre_en_o = (state_reg == S_PRE);
  assign step_o   = (state_reg == S_RUN);
  assign done_o   = (state_reg == S_FIN);
  assign first_o  = step_o && (cnt_reg == CNT_LAST);
  assign last_o   = step_o && (cnt_reg == '0);
  assign digit_o  = step_o ? a_sh_reg[NBITS-1 -: PBITS] : '0;

endmodule

// File: tb/tb_mod_mul_il_seq.sv
// Randomised scoreboard bench for mod_mul_il_seq at NBITS=8, PBITS=2.
module tb_mod_mul_il_seq;
  localparam int NBITS = 8;
  localparam int PBITS = 2;
  localparam int ND    = NBITS / PBITS;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
`ifdef MMIL_SEQ_REUSE_EN
  logic             reuse_i;
`endif
  logic             ready_o;
  logic [NBITS-1:0] a_i;
  logic             pre_en_o;
  logic             pre_done_i;
  logic             step_o;
  logic [PBITS-1:0] digit_o;
  logic             first_o;
  logic             last_o;
  logic             done_o;
  logic             busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [PBITS-1:0] digit;
    bit               first;
    bit               last;
  } exp_t;

  exp_t exp_q[$];
  bit   done_pending = 1'b0;

  mod_mul_il_seq #(.NBITS(NBITS), .PBITS(PBITS)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
`ifdef MMIL_SEQ_REUSE_EN
    .reuse_i    (reuse_i),
`endif
    .ready_o    (ready_o),
    .a_i        (a_i),
    .pre_en_o   (pre_en_o),
    .pre_done_i (pre_done_i),
    .step_o     (step_o),
    .digit_o    (digit_o),
    .first_o    (first_o),
    .last_o     (last_o),
    .done_o     (done_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected digit sequence: base-2^PBITS digits of a, most significant first.
  task automatic push_expected(input logic [NBITS-1:0] a);
    int av;
    exp_t e;
    av = int'(a);
    for (int k = 0; k < ND; k++) begin
      e.digit = PBITS'((av >> (NBITS - PBITS * (k + 1))) % (1 << PBITS));
      e.first = (k == 0);
      e.last  = (k == ND - 1);
      exp_q.push_back(e);
      $display("push a=%02h digit[%0d]=%0d", a, k, e.digit);
    end
  endtask

  // Monitor/scoreboard: pops on every step, checks done follows the final step by one cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
      done_pending = 1'b0;
    end else begin
      chk("done_timing", done_o, done_pending);
      done_pending = 1'b0;
      if (step_o) begin
        if (exp_q.size() == 0) begin
          chk("step_unexpected", step_o, 0);
        end else begin
          e = exp_q.pop_front();
          chk("digit", digit_o, e.digit);
          chk("first", first_o, e.first);
          chk("last", last_o, e.last);
          done_pending = e.last;
          $display("step digit=%0d first=%0b last=%0b", digit_o, first_o, last_o);
        end
      end
      if (start_i && ready_o) push_expected(a_i);
    end
  end

  // Full operation through PRE; waitc idle cycles in WAIT_PRE before the done pulse.
  task automatic run_op(input logic [NBITS-1:0] a, input int waitc, input bit spur);
    start_i = 1'b1;
    a_i     = a;
    chk("accept_ready", ready_o, 1);
    tick();
    start_i = 1'b0;
    if (spur) pre_done_i = 1'b1;
    chk("pre_en_pulse", pre_en_o, 1);
    chk("pre_busy", busy_o, 1);
    tick();
    pre_done_i = 1'b0;
    chk("pre_en_single", pre_en_o, 0);
    for (int i = 0; i < waitc; i++) begin
      chk("wait_no_step", step_o, 0);
      chk("wait_busy", busy_o, 1);
      tick();
    end
    pre_done_i = 1'b1;
    chk("wait_no_step", step_o, 0);
    tick();
    pre_done_i = 1'b0;
    for (int k = 0; k < ND; k++) begin
      chk("run_step", step_o, 1);
      chk("run_last", last_o, (k == ND - 1));
      chk("run_no_pre_en", pre_en_o, 0);
      if (spur && k == 1) begin
        pre_done_i = 1'b1;
        start_i    = 1'b1;
        a_i        = 8'hFF;
      end
      tick();
      pre_done_i = 1'b0;
      start_i    = 1'b0;
    end
    chk("fin_done", done_o, 1);
    chk("fin_no_step", step_o, 0);
    chk("fin_not_ready", ready_o, 0);
    tick();
    chk("idle_ready", ready_o, 1);
    chk("idle_busy", busy_o, 0);
    $display("op a=%02h wait=%0d spur=%0b complete", a, waitc, spur);
  endtask

  initial begin
    rst        = 1'b1;
    start_i    = 1'b0;
    a_i        = '0;
    pre_done_i = 1'b0;
`ifdef MMIL_SEQ_REUSE_EN
    reuse_i    = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_step", step_o, 0);
    chk("rst_pre_en", pre_en_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_digit", digit_o, 0);

    // Basic: pre_done at T+4, steps T+5..T+8
    run_op(8'hB4, 2, 1'b0);

    // pre_done in IDLE has no effect
    pre_done_i = 1'b1;
    tick();
    pre_done_i = 1'b0;
    chk("idle_pre_done_ready", ready_o, 1);
    chk("idle_pre_done_busy", busy_o, 0);
    chk("idle_pre_done_step", step_o, 0);
    tick();

    // Stall and spurious inputs
    run_op(8'h5A, 50, 1'b0);
    run_op(8'h93, 3, 1'b1);

    // Reset after the second step
    start_i = 1'b1;
    a_i     = 8'h6C;
    tick();
    start_i = 1'b0;
    tick();
    pre_done_i = 1'b1;
    tick();
    pre_done_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_done", done_o, 0);
    chk("midrst_step", step_o, 0);
    chk("midrst_busy", busy_o, 0);
    tick();
    chk("midrst_no_done", done_o, 0);
    run_op(8'h27, 1, 1'b0);

    // Back-to-back with start held high
    start_i = 1'b1;
    a_i     = 8'hC6;
    chk("b2b_ready", ready_o, 1);
    tick();
    a_i = 8'h39;
    chk("b2b_pre_en1", pre_en_o, 1);
    repeat (3) tick();
    pre_done_i = 1'b1;
    tick();
    pre_done_i = 1'b0;
    repeat (4) tick();
    chk("b2b_done1", done_o, 1);
    chk("b2b_fin_ready", ready_o, 0);
    tick();
    chk("b2b_reaccept_ready", ready_o, 1);
    tick();
    start_i = 1'b0;
    chk("b2b_pre_en2", pre_en_o, 1);
    tick();
    pre_done_i = 1'b1;
    tick();
    pre_done_i = 1'b0;
    repeat (4) tick();
    chk("b2b_done2", done_o, 1);
    tick();
    chk("b2b_idle", ready_o, 1);

`ifdef MMIL_SEQ_REUSE_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    reuse_i = 1'b1;
    run_op(8'hE1, 1, 1'b0);
    start_i = 1'b1;
    a_i     = 8'h4D;
    chk("reuse_ready", ready_o, 1);
    tick();
    start_i = 1'b0;
    chk("reuse_no_pre_en", pre_en_o, 0);
    chk("reuse_step1", step_o, 1);
    chk("reuse_first", first_o, 1);
    repeat (3) tick();
    chk("reuse_last", last_o, 1);
    tick();
    chk("reuse_done", done_o, 1);
    tick();
    chk("reuse_idle", ready_o, 1);
    reuse_i = 1'b0;
`endif

    for (int n = 0; n < 15; n++) begin
      run_op(NBITS'($urandom), int'($urandom_range(0, 6)), 1'($urandom));
      if ($urandom_range(0, 1) == 1) tick();
    end

    repeat (2) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
